// File: rtl/time_keeper.sv
// time_keeper
//   Time-of-day counter plus alarm-set registers that feed the alarm
//   comparator. A mode FSM (RUN / SET_TIME / SET_ALARM) routes the
//   minute/hour advance buttons to either the time or the alarm registers.
//   The alarmon button toggles the alarm-enable flag in any mode.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     When defined, a held minadv/hrsadv in a set mode re-advances every
//     REPEAT_CYCLES cycles after the press cycle.
//
// Parameters
//   TICKS_PER_SEC : clk cycles per second of time (>=1)
//   REPEAT_CYCLES : auto-repeat period in cycles (>=2, AUTO_REPEAT_EN only)
//
// Ports
//   clk, rst_n           : clock, async active-low reset
//   timeset, alarmset    : mode request levels (timeset has priority)
//   minadv, hrsadv       : advance buttons (edge detected)
//   alarmon              : alarm-enable toggle button (edge detected)
//   tsec, tmin, thrs     : current time, 7-bit binary
//   amin, ahrs           : alarm time, 7-bit binary
//   enable               : alarm armed
module time_keeper #(
  parameter int TICKS_PER_SEC = 4,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       timeset,
  input  logic       alarmset,
  input  logic       minadv,
  input  logic       hrsadv,
  input  logic       alarmon,
  output logic [6:0] tsec,
  output logic [6:0] tmin,
  output logic [6:0] thrs,
  output logic [6:0] amin,
  output logic [6:0] ahrs,
  output logic       enable
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {RUN, SET_TIME, SET_ALARM} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc;
  logic          minadv_q, hrsadv_q, alarmon_q;
  logic          min_press, hrs_press, alm_press;
  logic          min_adv, hrs_adv;
  logic          tick;

  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] maxv);
    return (v >= maxv) ? 7'd0 : v + 7'd1;
  endfunction

  always_comb begin
    state_nx = RUN;
    if (timeset)       state_nx = SET_TIME;
    else if (alarmset) state_nx = SET_ALARM;
  end

  assign min_press = minadv  & ~minadv_q;
  assign hrs_press = hrsadv  & ~hrsadv_q;
  assign alm_press = alarmon & ~alarmon_q;

  // Time is frozen only in SET_TIME; the tick uses the registered state so a
  // tick coinciding with set-mode entry is still honoured.
  assign tick = (state != SET_TIME) && (presc == PW'(TICKS_PER_SEC - 1));

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);

  logic [RW-1:0] min_rcnt, hrs_rcnt;
  logic          hold_ok, min_held, hrs_held, min_rep, hrs_rep;

  // Repeat counts only while staying in the same set mode; any mode change
  // or release restarts the count from the next press.
  assign hold_ok  = (state != RUN) && (state_nx == state);
  assign min_held = hold_ok && minadv && minadv_q;
  assign hrs_held = hold_ok && hrsadv && hrsadv_q;
  assign min_rep  = min_held && (min_rcnt == RW'(REPEAT_CYCLES - 1));
  assign hrs_rep  = hrs_held && (hrs_rcnt == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_rcnt <= '0;
      hrs_rcnt <= '0;
    end else begin
      if (!min_held || min_rep) min_rcnt <= '0;
      else                      min_rcnt <= min_rcnt + RW'(1);
      if (!hrs_held || hrs_rep) hrs_rcnt <= '0;
      else                      hrs_rcnt <= hrs_rcnt + RW'(1);
    end
  end

  assign min_adv = min_press | min_rep;
  assign hrs_adv = hrs_press | hrs_rep;
`else
  assign min_adv = min_press;
  assign hrs_adv = hrs_press;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      presc     <= '0;
      minadv_q  <= 1'b0;
      hrsadv_q  <= 1'b0;
      alarmon_q <= 1'b0;
      tsec      <= '0;
      tmin      <= '0;
      thrs      <= '0;
      amin      <= '0;
      ahrs      <= '0;
      enable    <= 1'b0;
    end else begin
      state     <= state_nx;
      minadv_q  <= minadv;
      hrsadv_q  <= hrsadv;
      alarmon_q <= alarmon;

      if (alm_press) enable <= ~enable;

      if (state == SET_TIME) begin
        if (min_adv) tmin <= wrap_inc(tmin, 7'd59);
        if (hrs_adv) thrs <= wrap_inc(thrs, 7'd23);
        // Leaving time-set restarts the second from zero.
        if (state_nx != SET_TIME) begin
          tsec  <= '0;
          presc <= '0;
        end
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          tsec <= wrap_inc(tsec, 7'd59);
          if (tsec == 7'd59) begin
            tmin <= wrap_inc(tmin, 7'd59);
            if (tmin == 7'd59) thrs <= wrap_inc(thrs, 7'd23);
          end
        end
        if (state == SET_ALARM) begin
          if (min_adv) amin <= wrap_inc(amin, 7'd59);
          if (hrs_adv) ahrs <= wrap_inc(ahrs, 7'd23);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst_n, timeset, alarmset, minadv, hrsadv, alarmon;
  logic [6:0] tsec, tmin, thrs, amin, ahrs;
  logic       enable;

  int tests = 0;
  int fails = 0;

  time_keeper #(.TICKS_PER_SEC(4), .REPEAT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .timeset(timeset), .alarmset(alarmset),
    .minadv(minadv), .hrsadv(hrsadv), .alarmon(alarmon),
    .tsec(tsec), .tmin(tmin), .thrs(thrs), .amin(amin), .ahrs(ahrs),
    .enable(enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_min();
    minadv = 1'b1; step(1); minadv = 1'b0; step(1);
  endtask

  task automatic press_hrs();
    hrsadv = 1'b1; step(1); hrsadv = 1'b0; step(1);
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".thrs"}, thrs, 7'(h));
    chk({tag, ".tmin"}, tmin, 7'(m));
    chk({tag, ".tsec"}, tsec, 7'(s));
  endtask

  initial begin
    rst_n = 1'b0; timeset = 1'b0; alarmset = 1'b0;
    minadv = 1'b0; hrsadv = 1'b0; alarmon = 1'b0;
    #12;
    chk_time("rst", 0, 0, 0);
    chk("rst.amin", amin, 7'd0);
    chk("rst.ahrs", ahrs, 7'd0);
    chk("rst.enable", {6'd0, enable}, 7'd0);

    // 1: free run
    rst_n = 1'b1;
    step(236);
    chk_time("run236", 0, 0, 59);
    step(4);
    chk_time("run240", 0, 1, 0);

    // 2: set 23:59 then roll over to midnight
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    chk_time("rst2", 0, 0, 0);
    timeset = 1'b1; step(1);
    for (int i = 0; i < 23; i++) press_hrs();
    for (int i = 0; i < 59; i++) press_min();
    chk_time("set2359", 23, 59, 0);
    timeset = 1'b0; step(1);
    step(236);
    chk_time("pass235959", 23, 59, 59);
    step(4);
    chk_time("midnight", 0, 0, 0);

    // 3: alarm set while time runs (65 cycles -> 16 ticks)
    alarmset = 1'b1; step(1);
    for (int i = 0; i < 2; i++) press_hrs();
    for (int i = 0; i < 30; i++) press_min();
    chk("alm.ahrs", ahrs, 7'd2);
    chk("alm.amin", amin, 7'd30);
    chk_time("alm.run", 0, 0, 16);
    step(3);
    chk("alm.tick", tsec, 7'd17);
    alarmset = 1'b0; step(1);

    // 4: timeset priority, then minute wrap without hour carry
    timeset = 1'b1; alarmset = 1'b1; step(1);
    press_min();
    chk("prio.tmin", tmin, 7'd1);
    chk("prio.amin", amin, 7'd30);
    chk("frozen.tsec", tsec, 7'd17);
    for (int i = 0; i < 58; i++) press_min();
    chk("tmin59", tmin, 7'd59);
    press_min();
    chk("wrap.tmin", tmin, 7'd0);
    chk("wrap.thrs", thrs, 7'd0);

    // 5: held minadv
    minadv = 1'b1; step(20); minadv = 1'b0; step(1);
`ifdef AUTO_REPEAT_EN
    chk("hold.tmin", tmin, 7'd3);
`else
    chk("hold.tmin", tmin, 7'd1);
`endif
    timeset = 1'b0; alarmset = 1'b0; step(1);
    chk("leave.tsec", tsec, 7'd0);

    // 6: alarm-enable toggles, then async reset mid-second
    alarmon = 1'b1; step(1); chk("en1", {6'd0, enable}, 7'd1);
    alarmon = 1'b0; step(1);
    alarmon = 1'b1; step(1); chk("en0", {6'd0, enable}, 7'd0);
    alarmon = 1'b0; step(1);
    alarmon = 1'b1; step(1); chk("en1b", {6'd0, enable}, 7'd1);
    alarmon = 1'b0; step(2);
    #2 rst_n = 1'b0;
    #1;
    chk_time("arst", 0, 0, 0);
    chk("arst.amin", amin, 7'd0);
    chk("arst.ahrs", ahrs, 7'd0);
    chk("arst.enable", {6'd0, enable}, 7'd0);
    rst_n = 1'b1;
    step(3);
    chk("post.tsec3", tsec, 7'd0);
    step(1);
    chk("post.tsec4", tsec, 7'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
